// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 signed max-pool over a raster-ordered feature map.
// Pair maxima from even rows are kept in a half-row line buffer and merged on odd rows.
module maxpool2x2_stream #(
    parameter int DATA_W  = 16,
    parameter int IN_COLS = 28,
    parameter int IN_ROWS = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_en,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              row_done,
    output logic              frame_done
);

    localparam int HALF  = IN_COLS / 2;
    localparam int COL_W = (IN_COLS > 2) ? $clog2(IN_COLS) : 1;
    localparam int ROW_W = (IN_ROWS > 2) ? $clog2(IN_ROWS) : 1;
    localparam int IDX_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_ROWS - 1);

    if ((IN_COLS % 2) != 0 || IN_COLS < 2) begin : g_bad_cols
        $error("maxpool2x2_stream: IN_COLS must be even and at least 2");
    end
    if ((IN_ROWS % 2) != 0 || IN_ROWS < 2) begin : g_bad_rows
        $error("maxpool2x2_stream: IN_ROWS must be even and at least 2");
    end

    typedef enum logic {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } state_t;

    function automatic logic [DATA_W-1:0] max_signed(input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    state_t             r_state;
    state_t             w_state_next;
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic [DATA_W-1:0]  r_pair;
    logic [DATA_W-1:0]  r_linebuf [HALF];
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_row_done;
    logic               r_frame_done;

    logic               w_col_last;
    logic               w_row_last;
    logic               w_odd_col;
    logic [IDX_W-1:0]   w_idx;
    logic [DATA_W-1:0]  w_pmax;
    logic [DATA_W-1:0]  w_result;
    logic               w_lb_we;
    logic               w_emit;

    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);
    assign w_odd_col  = r_col[0];
    assign w_idx      = IDX_W'(r_col >> 1'b1);
    assign w_pmax     = max_signed(r_pair, in_data);
    assign w_result   = max_signed(r_linebuf[w_idx], w_pmax);
    assign w_lb_we    = in_en && w_odd_col && (r_state == ROW_EVEN);
    assign w_emit     = in_en && w_odd_col && (r_state == ROW_ODD);

    // State register for the even/odd row phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ROW_EVEN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Row phase flips when the last column of a row is accepted.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ROW_EVEN: begin
                if (in_en && w_col_last) begin
                    w_state_next = ROW_ODD;
                end else begin
                    w_state_next = ROW_EVEN;
                end
            end
            ROW_ODD: begin
                if (in_en && w_col_last) begin
                    w_state_next = ROW_EVEN;
                end else begin
                    w_state_next = ROW_ODD;
                end
            end
            default: w_state_next = ROW_EVEN;
        endcase
    end

    // Raster position counters and the even-column pair register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col  <= '0;
            r_row  <= '0;
            r_pair <= '0;
        end else if (in_en) begin
            if (!w_odd_col) begin
                r_pair <= in_data;
            end
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Line buffer: never reset, written only on even rows.
    always_ff @(posedge clk) begin
        if (w_lb_we) begin
            r_linebuf[w_idx] <= w_pmax;
        end
    end

    // Registered pooled output; out_data holds while no window completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_row_done   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_out_valid  <= w_emit;
            r_row_done   <= w_emit && w_col_last;
            r_frame_done <= w_emit && w_col_last && w_row_last;
            if (w_emit) begin
                r_out_data <= w_result;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign row_done   = r_row_done;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Scoreboard bench for maxpool2x2_stream: a 4x4 instance for directed windows and a
// 28x28 instance for full-frame, stall, back-to-back and mid-frame reset scenarios.
module tb_maxpool2x2_stream;

    typedef struct {
        logic [15:0] data;
        logic        rd;
        logic        fd;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_en4,  in_en28;
    logic [15:0] in_data4, in_data28;
    logic        out_valid4, out_valid28;
    logic [15:0] out_data4, out_data28;
    logic        rd4, rd28, fd4, fd28;

    exp_t        q4[$];
    exp_t        q28[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          pulses4  = 0;
    int          pulses28 = 0;
    int          fdone28  = 0;
    logic [15:0] fr4  [16];
    logic [15:0] fr28 [784];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    maxpool2x2_stream #(.DATA_W(16), .IN_COLS(4), .IN_ROWS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_en(in_en4), .in_data(in_data4),
        .out_valid(out_valid4), .out_data(out_data4), .row_done(rd4), .frame_done(fd4)
    );

    maxpool2x2_stream #(.DATA_W(16), .IN_COLS(28), .IN_ROWS(28)) u_dut28 (
        .clk(clk), .rst_n(rst_n), .in_en(in_en28), .in_data(in_data28),
        .out_valid(out_valid28), .out_data(out_data28), .row_done(rd28), .frame_done(fd28)
    );

    function automatic logic [15:0] smax(input logic [15:0] a, input logic [15:0] b);
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

    function automatic logic [15:0] max4(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c, input logic [15:0] d);
        return smax(smax(a, b), smax(c, d));
    endfunction

    // Pop and compare every output pulse of the 4x4 instance.
    always @(negedge clk) begin
        if (out_valid4) begin
            exp_t e;
            pulses4 = pulses4 + 1;
            checks  = checks + 1;
            if (q4.size() == 0) begin
                failures = failures + 1;
                $display("FAIL dut4_unexpected: out_valid with data=%h at cycle %0d, none expected",
                         out_data4, cyc);
            end else begin
                e = q4.pop_front();
                if ({out_data4, rd4, fd4} !== {e.data, e.rd, e.fd} || cyc != e.cyc) begin
                    failures = failures + 1;
                    $display("FAIL dut4_out: got data=%h rd=%b fd=%b cyc=%0d, want data=%h rd=%b fd=%b cyc=%0d",
                             out_data4, rd4, fd4, cyc, e.data, e.rd, e.fd, e.cyc);
                end
            end
        end
    end

    // Pop and compare every output pulse of the 28x28 instance.
    always @(negedge clk) begin
        if (out_valid28) begin
            exp_t e;
            pulses28 = pulses28 + 1;
            if (fd28) fdone28 = fdone28 + 1;
            checks = checks + 1;
            if (q28.size() == 0) begin
                failures = failures + 1;
                $display("FAIL dut28_unexpected: out_valid with data=%h at cycle %0d, none expected",
                         out_data28, cyc);
            end else begin
                e = q28.pop_front();
                if ({out_data28, rd28, fd28} !== {e.data, e.rd, e.fd} || cyc != e.cyc) begin
                    failures = failures + 1;
                    $display("FAIL dut28_out: got data=%h rd=%b fd=%b cyc=%0d, want data=%h rd=%b fd=%b cyc=%0d",
                             out_data28, rd28, fd28, cyc, e.data, e.rd, e.fd, e.cyc);
                end
            end
        end
    end

    task automatic send4();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    exp_t e;
                    e.data = max4(fr4[(r-1)*4+c-1], fr4[(r-1)*4+c], fr4[r*4+c-1], fr4[r*4+c]);
                    e.rd   = (c == 3);
                    e.fd   = (c == 3) && (r == 3);
                    e.cyc  = cyc + 1;
                    q4.push_back(e);
                end
                in_en4   = 1'b1;
                in_data4 = fr4[r*4+c];
                @(posedge clk); #1;
            end
        end
        in_en4 = 1'b0;
    endtask

    task automatic send28(input bit stall, input int n_samples);
        for (int i = 0; i < n_samples; i++) begin
            int r = i / 28;
            int c = i % 28;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                exp_t e;
                e.data = max4(fr28[(r-1)*28+c-1], fr28[(r-1)*28+c], fr28[r*28+c-1], fr28[r*28+c]);
                e.rd   = (c == 27);
                e.fd   = (c == 27) && (r == 27);
                e.cyc  = cyc + 1;
                q28.push_back(e);
            end
            in_en28   = 1'b1;
            in_data28 = fr28[i];
            @(posedge clk); #1;
            if (stall) begin
                in_en28   = 1'b0;
                in_data28 = 16'hDEAD;
                @(posedge clk); #1;
            end
        end
        in_en28 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_en4 = 1'b0; in_en28 = 1'b0;
        in_data4 = 16'h0000; in_data28 = 16'h0000;
        idle(3);
        checks = checks + 1;
        if ({out_valid4, out_data4, rd4, fd4} !== {1'b0, 16'h0000, 1'b0, 1'b0}) begin
            failures = failures + 1;
            $display("FAIL reset_dut4: got v=%b d=%h rd=%b fd=%b, want all zero", out_valid4, out_data4, rd4, fd4);
        end
        checks = checks + 1;
        if ({out_valid28, out_data28, rd28, fd28} !== {1'b0, 16'h0000, 1'b0, 1'b0}) begin
            failures = failures + 1;
            $display("FAIL reset_dut28: got v=%b d=%h rd=%b fd=%b, want all zero", out_valid28, out_data28, rd28, fd28);
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_raster4();
        for (int i = 0; i < 16; i++) fr4[i] = 16'(i);
        pulses4 = 0;
        send4();
        idle(3);
        checks = checks + 1;
        if (pulses4 != 4 || q4.size() != 0 || out_data4 !== 16'd15) begin
            failures = failures + 1;
            $display("FAIL raster4: got pulses=%0d pending=%0d last=%h, want pulses=4 pending=0 last=000f",
                     pulses4, q4.size(), out_data4);
        end
    endtask

    task automatic test_signed();
        fr4[0]  = 16'hFFFD; fr4[1]  = 16'hFFFF; fr4[4]  = 16'hFFF8; fr4[5]  = 16'hFFFE;
        fr4[2]  = 16'h8000; fr4[3]  = 16'h8000; fr4[6]  = 16'h8000; fr4[7]  = 16'h8000;
        fr4[8]  = 16'h7FFF; fr4[9]  = 16'hFFFF; fr4[12] = 16'h0000; fr4[13] = 16'h8000;
        fr4[10] = 16'hFFF9; fr4[11] = 16'hFFF9; fr4[14] = 16'hFFF9; fr4[15] = 16'hFFF9;
        pulses4 = 0;
        send4();
        idle(3);
        checks = checks + 1;
        if (pulses4 != 4 || q4.size() != 0 || out_data4 !== 16'hFFF9) begin
            failures = failures + 1;
            $display("FAIL signed: got pulses=%0d pending=%0d last=%h, want pulses=4 pending=0 last=fff9",
                     pulses4, q4.size(), out_data4);
        end
    endtask

    task automatic test_corners();
        for (int i = 0; i < 16; i++) fr4[i] = 16'(-(i + 1));
        fr4[0]  = 16'd100;
        fr4[3]  = 16'd101;
        fr4[12] = 16'd102;
        fr4[15] = 16'd103;
        pulses4 = 0;
        send4();
        idle(3);
        checks = checks + 1;
        if (pulses4 != 4 || q4.size() != 0) begin
            failures = failures + 1;
            $display("FAIL corners: got pulses=%0d pending=%0d, want pulses=4 pending=0", pulses4, q4.size());
        end
    endtask

    task automatic test_continuous28();
        for (int i = 0; i < 784; i++) fr28[i] = 16'($urandom);
        pulses28 = 0; fdone28 = 0;
        send28(1'b0, 784);
        idle(3);
        checks = checks + 1;
        if (pulses28 != 196 || fdone28 != 1 || q28.size() != 0) begin
            failures = failures + 1;
            $display("FAIL continuous28: got pulses=%0d frame_done=%0d pending=%0d, want 196/1/0",
                     pulses28, fdone28, q28.size());
        end
    endtask

    task automatic test_stall28();
        pulses28 = 0; fdone28 = 0;
        send28(1'b1, 784);
        idle(3);
        checks = checks + 1;
        if (pulses28 != 196 || fdone28 != 1 || q28.size() != 0) begin
            failures = failures + 1;
            $display("FAIL stall28: got pulses=%0d frame_done=%0d pending=%0d, want 196/1/0",
                     pulses28, fdone28, q28.size());
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 784; i++) fr28[i] = 16'($urandom);
        pulses28 = 0; fdone28 = 0;
        send28(1'b0, 784);
        for (int i = 0; i < 784; i++) fr28[i] = 16'($urandom);
        send28(1'b0, 784);
        idle(3);
        checks = checks + 1;
        if (pulses28 != 392 || fdone28 != 2 || q28.size() != 0) begin
            failures = failures + 1;
            $display("FAIL back_to_back: got pulses=%0d frame_done=%0d pending=%0d, want 392/2/0",
                     pulses28, fdone28, q28.size());
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 784; i++) fr28[i] = 16'($urandom);
        send28(1'b0, 30);
        idle(1);
        rst_n = 1'b0;
        #2;
        checks = checks + 1;
        if (out_valid28 !== 1'b0 || q28.size() != 0) begin
            failures = failures + 1;
            $display("FAIL reset_mid_during: got v=%b pending=%0d, want v=0 pending=0", out_valid28, q28.size());
        end
        idle(2);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks = checks + 1;
        if (out_valid28 !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL reset_mid_after: got v=%b, want 0", out_valid28);
        end
        for (int i = 0; i < 784; i++) fr28[i] = 16'($urandom);
        pulses28 = 0; fdone28 = 0;
        send28(1'b0, 784);
        idle(3);
        checks = checks + 1;
        if (pulses28 != 196 || fdone28 != 1 || q28.size() != 0) begin
            failures = failures + 1;
            $display("FAIL reset_mid_frame: got pulses=%0d frame_done=%0d pending=%0d, want 196/1/0",
                     pulses28, fdone28, q28.size());
        end
    endtask

    initial begin
        test_reset();
        test_raster4();
        test_signed();
        test_corners();
        test_continuous28();
        test_stall28();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
